// File: rtl/lane_serializer_pkg.sv
// Shared types, default widths and index-width helper for the lane serializer
// and its companion lane index counter.
package lane_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } ser_state_t;

  localparam int LANES_DEF  = 4;
  localparam int LANE_W_DEF = 64;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/lane_serializer_if.sv
// Parallel-in / single-lane-out bus of the lane serializer.
// A transfer happens on a rising clk edge where valid && ready; a source holds
// valid and its payload stable until ready, and ready may depend on valid.
interface lane_serializer_if
  import lane_serializer_pkg::*;
#(
  parameter int N = LANES_DEF,
  parameter int W = LANE_W_DEF
);

   logic                  in_valid;
   logic                  in_ready;
   logic [W-1:0]          in_data [N];
   logic                  out_valid;
   logic                  out_ready;
   logic [W-1:0]          out_data;
   logic [idx_w(N)-1:0]   out_idx;
   logic                  out_last;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last
   );

endinterface

// File: rtl/lane_idx_counter.sv
// Lane index counter: counts 0..N-1 and wraps to 0, so non-power-of-2 lane
// counts never reach the unused codes. Shared with the deserializer.
module lane_idx_counter
  import lane_serializer_pkg::*;
#(
  parameter int N = LANES_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                inc,
   output logic [idx_w(N)-1:0] idx,
   output logic                last
);

   localparam int IW = idx_w(N);

   logic [IW-1:0] r_idx;

   assign idx  = r_idx;
   assign last = (r_idx == IW'(N - 1));

   // clr wins over inc so a reload on the final beat restarts at lane 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
      end else if (clr) begin
         r_idx <= '0;
      end else if (inc) begin
         r_idx <= last ? '0 : r_idx + 1'b1;
      end
   end

endmodule

// File: rtl/lane_serializer.sv
// Drains an N-lane parallel array one lane per beat, lane 0 first, with
// back-to-back reload on the final beat so the output never bubbles.
module lane_serializer
  import lane_serializer_pkg::*;
#(
  parameter int N = LANES_DEF,
  parameter int W = LANE_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   lane_serializer_if.slave    bus,
   output ser_state_t          o_dbg_state
);

   localparam int IW = idx_w(N);

   if (N < 2) begin : g_bad_lanes
      $error("lane_serializer: N must be at least 2");
   end

   ser_state_t     r_state;
   logic [W-1:0]   r_buf [N];
   logic [IW-1:0]  w_idx;
   logic           w_last;
   logic           w_accept;
   logic           w_beat;

   assign bus.out_valid = (r_state == DRAIN);
   assign bus.out_last  = bus.out_valid && w_last;
   assign bus.out_data  = r_buf[w_idx];
   assign bus.out_idx   = w_idx;

   // Reload is only allowed while the last lane is leaving this very cycle
   assign bus.in_ready  = rst_n && ((r_state == IDLE) || (bus.out_last && bus.out_ready));

   assign w_accept      = bus.in_valid && bus.in_ready;
   assign w_beat        = bus.out_valid && bus.out_ready;
   assign o_dbg_state   = r_state;

   lane_idx_counter #(.N(N)) u_idx (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_accept),
      .inc   (w_beat),
      .idx   (w_idx),
      .last  (w_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         for (int i = 0; i < N; i++) begin
            r_buf[i] <= '0;
         end
      end else begin
         if (w_accept) begin
            r_state <= DRAIN;
            r_buf   <= bus.in_data;
         end else if (w_beat && w_last) begin
            r_state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: a 4x64 instance and a 3x16 instance, directed
// arrays, queue-based scoreboard per instance.
module tb_lane_serializer;
   import lane_serializer_pkg::*;

   logic       clk;
   logic       rst_n;
   ser_state_t st4;
   ser_state_t st3;

   int n_checks = 0;
   int n_errors = 0;

   logic [66:0] exp_q4[$];
   logic [18:0] exp_q3[$];

   lane_serializer_if #(.N(4), .W(64)) bus4 ();
   lane_serializer_if #(.N(3), .W(16)) bus3 ();

   lane_serializer #(.N(4), .W(64)) u_dut4 (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus4),
      .o_dbg_state (st4)
   );

   lane_serializer #(.N(3), .W(16)) u_dut3 (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus3),
      .o_dbg_state (st3)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // drivers
   task automatic drive4(input logic [3:0][63:0] lanes, input string nm);
      for (int i = 0; i < 4; i++) bus4.in_data[i] = lanes[i];
      bus4.in_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus4.in_ready) begin
            for (int i = 0; i < 4; i++) exp_q4.push_back({(i == 3), 2'(i), lanes[i]});
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
      end
      n_checks++;
      n_errors++;
      $display("FAIL %s_accept actual=timeout required=accepted", nm);
   endtask

   task automatic drive3(input logic [2:0][15:0] lanes, input string nm);
      for (int i = 0; i < 3; i++) bus3.in_data[i] = lanes[i];
      bus3.in_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus3.in_ready) begin
            for (int i = 0; i < 3; i++) exp_q3.push_back({(i == 2), 2'(i), lanes[i]});
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
      end
      n_checks++;
      n_errors++;
      $display("FAIL %s_accept actual=timeout required=accepted", nm);
   endtask

   // Expects n_beats gap-free beats with in_ready only on each final lane, then idle.
   task automatic run4(input int n_beats, input string nm);
      int c;
      for (c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus4.out_valid) break;
      end
      chk({nm, "_start"}, (c < 12), 1);
      for (int k = 0; k < n_beats; k++) begin
         chk({nm, "_valid"}, bus4.out_valid, 1);
         chk({nm, "_in_ready"}, bus4.in_ready, ((k % 4) == 3));
         @(negedge clk);
      end
      chk({nm, "_idle_valid"}, bus4.out_valid, 0);
      chk({nm, "_idle_ready"}, bus4.in_ready, 1);
   endtask

   // scoreboard monitors
   always @(negedge clk) begin : mon4
      logic [66:0] e;
      if (rst_n && bus4.out_valid) begin
         if (exp_q4.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL a_unexpected_beat actual=%0h required=none",
                     {bus4.out_last, bus4.out_idx, bus4.out_data});
         end else begin
            e = exp_q4[0];
            chk("a_beat", {bus4.out_last, bus4.out_idx, bus4.out_data}, e);
            chk("a_beat_in_ready", bus4.in_ready, e[66] && bus4.out_ready);
            if (bus4.out_ready) void'(exp_q4.pop_front());
         end
      end
   end

   always @(negedge clk) begin : mon3
      logic [18:0] e;
      if (rst_n && bus3.out_valid) begin
         if (exp_q3.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL b_unexpected_beat actual=%0h required=none",
                     {bus3.out_last, bus3.out_idx, bus3.out_data});
         end else begin
            e = exp_q3[0];
            chk("b_beat", {bus3.out_last, bus3.out_idx, bus3.out_data}, e);
            chk("b_beat_in_ready", bus3.in_ready, e[18] && bus3.out_ready);
            if (bus3.out_ready) void'(exp_q3.pop_front());
         end
      end
   end

   // stimulus
   initial begin
      rst_n          = 1'b0;
      bus4.in_valid  = 1'b0;
      bus4.out_ready = 1'b0;
      bus3.in_valid  = 1'b0;
      bus3.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) bus4.in_data[i] = '0;
      for (int i = 0; i < 3; i++) bus3.in_data[i] = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", bus4.out_valid, 0);
      chk("rst_out_data", bus4.out_data, 0);
      chk("rst_out_idx", bus4.out_idx, 0);
      chk("rst_out_last", bus4.out_last, 0);
      chk("rst_in_ready", bus4.in_ready, 0);
      chk("rst_state", st4, IDLE);
      chk("rst_b_in_ready", bus3.in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", bus4.in_ready, 1);
      chk("post_rst_out_valid", bus4.out_valid, 0);

      // single array, no backpressure
      bus4.out_ready = 1'b1;
      fork
         begin
            drive4({64'h3, 64'h2, 64'h1, 64'h0}, "single");
            bus4.in_valid = 1'b0;
         end
         run4(4, "single");
      join
      @(posedge clk);
      #1;

      // backpressure on lane 1
      drive4({64'h0000_0000_0000_0B03, 64'h0000_0000_0000_0B02,
              64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_0B00}, "bp");
      bus4.in_valid = 1'b0;
      @(posedge clk);
      #1;
      bus4.out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("bp_idx", bus4.out_idx, 1);
         chk("bp_data", bus4.out_data, 64'hDEAD_BEEF_0000_0001);
         chk("bp_in_ready", bus4.in_ready, 0);
         chk("bp_valid", bus4.out_valid, 1);
         @(posedge clk);
      end
      #1;
      bus4.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("bp_done_valid", bus4.out_valid, 0);
      chk("bp_done_ready", bus4.in_ready, 1);
      @(posedge clk);
      #1;

      // back-to-back arrays with in_valid held high
      fork
         begin
            drive4({64'hA3, 64'hA2, 64'hA1, 64'hA0}, "b2b_a");
            drive4({64'hB3, 64'hB2, 64'hB1, 64'hB0}, "b2b_b");
            bus4.in_valid = 1'b0;
         end
         run4(8, "b2b");
      join
      @(posedge clk);
      #1;

      // asynchronous reset while lane 2 is presented
      drive4({64'hC3, 64'hC2, 64'hC1, 64'hC0}, "rstmid");
      bus4.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rstmid_idx_before", bus4.out_idx, 2);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rstmid_valid", bus4.out_valid, 0);
      chk("rstmid_in_ready", bus4.in_ready, 0);
      chk("rstmid_state", st4, IDLE);
      exp_q4.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("rstmid_rel_ready", bus4.in_ready, 1);
      chk("rstmid_rel_valid", bus4.out_valid, 0);
      chk("rstmid_rel_idx", bus4.out_idx, 0);
      @(posedge clk);
      #1;
      fork
         begin
            drive4({64'hD3, 64'hD2, 64'hD1, 64'hD0}, "rstmid_next");
            bus4.in_valid = 1'b0;
         end
         run4(4, "rstmid_next");
      join
      @(posedge clk);
      #1;

      // input isolation: in_data churns during drain
      fork
         begin
            drive4({64'h1111_0003, 64'h1111_0002, 64'h1111_0001, 64'h1111_0000}, "iso");
            bus4.in_valid = 1'b0;
            repeat (6) begin
               for (int i = 0; i < 4; i++) bus4.in_data[i] = {$urandom, $urandom};
               @(posedge clk);
               #1;
            end
         end
         run4(4, "iso");
      join
      @(posedge clk);
      #1;

      // N = 3 wrap with back-to-back arrays
      bus3.out_ready = 1'b1;
      fork
         begin
            drive3({16'h0012, 16'h0011, 16'h0010}, "n3_a");
            drive3({16'h0022, 16'h0021, 16'h0020}, "n3_b");
            bus3.in_valid = 1'b0;
         end
         begin : n3_run
            int c;
            for (c = 0; c < 12; c++) begin
               @(negedge clk);
               if (bus3.out_valid) break;
            end
            chk("n3_start", (c < 12), 1);
            for (int k = 0; k < 6; k++) begin
               chk("n3_valid", bus3.out_valid, 1);
               chk("n3_idx", bus3.out_idx, k % 3);
               chk("n3_last", bus3.out_last, ((k % 3) == 2));
               @(negedge clk);
            end
            chk("n3_idle_valid", bus3.out_valid, 0);
            chk("n3_idle_ready", bus3.in_ready, 1);
         end
      join

      repeat (2) @(posedge clk);
      #1;
      chk("a_queue_empty", exp_q4.size(), 0);
      chk("b_queue_empty", exp_q3.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lane_serializer.md
Name: lane_serializer

Overview:
- Converts one N-lane parallel word array into a stream of N single-lane beats, lane 0 first.
- It is the reader/consumer counterpart of the per-lane array register stage: it takes the unpacked array that stage produces and drains it one lane per beat.
- It sits between the parallel lane register and any narrow W-bit consumer.
- Both sides use valid/ready handshakes. Full throughput is supported with back-to-back arrays.

Parameters:
- N, 4: number of lanes. Must be >= 2; an elaboration-time error is required otherwise.
- W, 64: lane data width in bits.

Ports:
- clk, input, 1: single clock. All logic is on the posedge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: the source presents a full array.
- in_ready, output, 1: the serializer accepts the array this cycle.
- in_data, input, [W-1:0] x [N-1:0] (unpacked): parallel lanes, index 0 to N-1.
- out_valid, output, 1: out_data holds a valid beat.
- out_ready, input, 1: the consumer accepts the beat this cycle.
- out_data, output, W: current lane word.
- out_idx, output, $clog2(N): lane index of the current beat.
- out_last, output, 1: high when out_idx == N-1 and out_valid is high.

Behaviour:
- States are IDLE and DRAIN. The state register, lane buffer buf[N-1:0], and index counter idx are all cleared asynchronously when rst_n is low.
- Reset values:
  - state = IDLE, idx = 0, buf = 0.
  - out_valid = 0, out_data = 0, out_idx = 0, out_last = 0.
  - in_ready = 0 while rst_n is low.
- in_ready is combinational:
  - 1 in IDLE.
  - 1 in DRAIN only when out_last is high and out_ready is high (back-to-back reload).
  - 0 otherwise.
- Accept event: in_valid && in_ready at a posedge.
  - buf <= in_data (all N lanes captured in the same cycle).
  - idx <= 0, state <= DRAIN.
- Latency: an array accepted at edge t presents lane 0 with out_valid = 1 after edge t. Lane k is presented no earlier than k cycles later.
- Output mapping: out_valid = (state == DRAIN), out_data = buf[idx], out_idx = idx.
- Beat transfer: out_valid && out_ready at a posedge.
  - If idx < N-1: idx <= idx + 1.
  - If idx == N-1 and no accept in the same cycle: state <= IDLE, idx <= 0.
  - If idx == N-1 and an accept occurs in the same cycle: reload takes priority. state stays DRAIN, idx <= 0, buf <= in_data, with no idle bubble.
- Backpressure: while out_valid && !out_ready, out_data, out_idx, and out_last hold stable. buf and idx must not change.
- Index width: idx is $clog2(N) bits and never exceeds N-1. For non-power-of-2 N (e.g. 3), idx wraps from N-1 to 0, not to 2^w-1.
- in_data is sampled only on the accept edge. Changes at other times have no effect on output.
- Reset mid-drain: all in-flight lanes are discarded. After rst_n rises, the block is in IDLE with in_ready = 1 and out_valid = 0. No partial beat is re-emitted.
- Sustained throughput: N beats every N cycles when out_ready is held 1 and in_valid is held 1.

Decomposition:
- Shared package lane_serializer_pkg:
  - typedef enum logic {IDLE, DRAIN} ser_state_t.
  - Function idx_w(N) returning $clog2(N).
  - localparam default widths (LANES_DEF = 4, LANE_W_DEF = 64).
- One natural sub-module, lane_idx_counter.
  - Ports: clk, rst_n, clr, inc. Output: idx.
  - Output last = (idx == N-1).
  - Wraps to 0 at N-1 and is reused by the matching deserializer.
- The lane buffer and FSM remain in lane_serializer.

Test Plan:
- Single array, no backpressure:
  - Stimulus: after reset, in_data = {0x..03, 0x..02, 0x..01, 0x..00}, in_valid for 1 cycle, out_ready = 1.
  - Required response: out_data 0, 1, 2, 3 on 4 consecutive cycles, out_idx 0..3, out_last only on 3, then out_valid = 0 and in_ready = 1.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles while lane 1 (0xDEAD_BEEF_0000_0001) is presented.
  - Required response: out_data, out_idx = 1 stable for all 3 cycles, in_ready = 0, lane 2 follows when out_ready rises.
- Back-to-back:
  - Stimulus: in_valid held 1 with arrays A = {A3..A0} then B = {B3..B0}, out_ready = 1.
  - Required response: 8 consecutive valid beats A0..A3, B0..B3 with no gap; in_ready = 1 exactly on the A3 cycle.
- Reset mid-drain:
  - Stimulus: assert rst_n = 0 asynchronously (between edges) while out_idx = 2.
  - Required response: out_valid drops immediately and in_ready = 0. After release, in_ready = 1 and the next array starts at lane 0.
- N = 3 wrap:
  - Stimulus: set N = 3, present two back-to-back arrays.
  - Required response: out_idx sequence 0, 1, 2, 0, 1, 2 (never 3); out_last high on each 2.
- Input isolation:
  - Stimulus: change in_data every cycle during DRAIN with in_valid = 0.
  - Required response: output beats match only the captured array.
